// File: rtl/chip8_mem_arbiter.sv
// Chip-8 RAM port arbiter: CPU accesses, program-area clear and ROM download share one
// read/write port. The CPU is held off while a clear or download owns the port.
`timescale 1ns/1ps
module chip8_mem_arbiter #(
  parameter logic [11:0] PROG_BASE = 12'h200,
  parameter bit          CLEAR_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_hold,
  input  logic        dl_active,
  input  logic        ld_valid,
  input  logic [11:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic        ld_overflow,
  output logic        mem_en,
  output logic        mem_write,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  // Handshakes: a CPU access completes on the cycle cpu_gnt is high; a loader byte is
  // consumed on any cycle with ld_valid & ld_ready, whether or not it fits in RAM.

  typedef enum logic [1:0] {S_CPU, S_CLEAR, S_LOAD} state_t;

  state_t      state, state_next;
  logic [11:0] clr_ctr, clr_ctr_next;
  logic        dl_q;
  logic        rd_pend;
  logic        ovf_set, ovf_clr;
  logic        dl_rise;
  logic [12:0] ld_sum;

  assign dl_rise = dl_active & ~dl_q;
  // One extra bit so an image byte past the top of RAM is detected instead of wrapping.
  assign ld_sum  = {1'b0, PROG_BASE} + {1'b0, ld_addr};

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_CPU;
      clr_ctr     <= PROG_BASE;
      dl_q        <= 1'b0;
      rd_pend     <= 1'b0;
      ld_overflow <= 1'b0;
    end else begin
      state   <= state_next;
      clr_ctr <= clr_ctr_next;
      dl_q    <= dl_active;
      rd_pend <= cpu_gnt & ~cpu_write;
      if (ovf_clr)      ld_overflow <= 1'b0;
      else if (ovf_set) ld_overflow <= 1'b1;
    end
  end

  // Read data is returned from the registered RAM output regardless of the current state,
  // so a read granted just before a download starts still completes.
  assign cpu_rvalid = rd_pend;
  assign cpu_rdata  = rd_pend ? mem_rdata : 8'h00;

  always_comb begin
    state_next   = state;
    clr_ctr_next = clr_ctr;
    cpu_gnt      = 1'b0;
    cpu_hold     = 1'b0;
    ld_ready     = 1'b0;
    mem_en       = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = 12'h000;
    mem_wdata    = 8'h00;
    ovf_set      = 1'b0;
    ovf_clr      = 1'b0;
    if (!reset) begin
      case (state)
        S_CPU: begin
          cpu_gnt   = cpu_req & ~dl_rise;
          mem_en    = cpu_gnt;
          mem_write = cpu_gnt & cpu_write;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
          if (dl_rise) begin
            ovf_clr    = 1'b1;
            state_next = CLEAR_EN ? S_CLEAR : S_LOAD;
          end
        end
        S_CLEAR: begin
          cpu_hold     = 1'b1;
          mem_en       = 1'b1;
          mem_write    = 1'b1;
          mem_addr     = clr_ctr;
          clr_ctr_next = clr_ctr + 12'd1;
          if (clr_ctr == 12'hFFF) begin
            clr_ctr_next = PROG_BASE;
            state_next   = dl_active ? S_LOAD : S_CPU;
          end
        end
        S_LOAD: begin
          cpu_hold = 1'b1;
          ld_ready = 1'b1;
          if (ld_valid) begin
            if (!ld_sum[12]) begin
              mem_en    = 1'b1;
              mem_write = 1'b1;
              mem_addr  = ld_sum[11:0];
              mem_wdata = ld_data;
            end else begin
              ovf_set = 1'b1;
            end
          end
          if (!dl_active) state_next = S_CPU;
        end
        default: state_next = S_CPU;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Bench for chip8_mem_arbiter: a behavioural RAM plus a reference memory image maintained
// from the arbiter's rules (clear region, load offset, overflow, CPU read/write ordering).
`timescale 1ns/1ps
module tb_chip8_mem_arbiter;

  localparam logic [11:0] PROG_BASE = 12'h200;
  localparam int          CLR_LEN   = 4096 - 512;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_write;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid, cpu_hold;
  logic [7:0]  cpu_rdata;
  logic        dl_active, ld_valid;
  logic [11:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready, ld_overflow;
  logic        mem_en, mem_write;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_mem [4096];
  logic [7:0] exp_q [$];
  logic       exp_ovf;

  // ---------------- clock/reset block ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  chip8_mem_arbiter #(.PROG_BASE(PROG_BASE), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .dl_active(dl_active), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_overflow(ld_overflow),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // ---------------- behavioural RAM (write-protected below PROG_BASE) ----------------
  logic [7:0]  ram [4096];
  logic [7:0]  ram_q;
  logic        bd_we = 1'b0, bd_fill = 1'b0;
  logic [11:0] bd_addr = '0, bd_lo = '0;
  logic [7:0]  bd_data = '0;
  int          bd_seed = 0;

  function automatic logic [7:0] fill_val(input int i, input int seed);
    return 8'(((i * 7 + seed) % 255) + 1);
  endfunction

  always @(posedge clk) begin
    if (bd_fill) begin
      for (int i = 0; i < 4096; i++)
        if (i >= int'(bd_lo)) ram[i] <= fill_val(i, bd_seed);
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_en) begin
      if (mem_write) begin
        if (mem_addr >= PROG_BASE) ram[mem_addr] <= mem_wdata;
      end else begin
        ram_q <= ram[mem_addr];
      end
    end
  end
  assign mem_rdata = ram_q;

  // ---------------- reference model ----------------
  function automatic void model_zero(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_mem[i] = 8'h00;
  endfunction

  function automatic void model_load(input logic [11:0] off, input logic [7:0] d);
    int sum;
    sum = int'(PROG_BASE) + int'(off);
    if (sum < 4096) exp_mem[sum] = d;
    else exp_ovf = 1'b1;
  endfunction

  function automatic int ram_diffs();
    int n;
    n = 0;
    for (int i = 0; i < 4096; i++) if (ram[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk); bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk); bd_we = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic bd_fill_from(input logic [11:0] lo, input int seed);
    @(negedge clk); bd_fill = 1'b1; bd_lo = lo; bd_seed = seed;
    @(negedge clk); bd_fill = 1'b0;
    for (int i = int'(lo); i < 4096; i++) exp_mem[i] = fill_val(i, seed);
  endtask

  // Steps through n clear cycles and counts cycles whose port activity deviates.
  task automatic run_clear(input logic [11:0] first, input int n, output int errs);
    errs = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      if (mem_en !== 1'b1 || mem_write !== 1'b1 || mem_addr !== first + 12'(i) ||
          mem_wdata !== 8'h00 || cpu_gnt !== 1'b0 || cpu_hold !== 1'b1 ||
          ld_ready !== 1'b0 || cpu_rvalid !== 1'b0) errs++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cpu_hold !== 1'b0 || ld_ready !== 1'b0 || ld_overflow !== 1'b0) begin
      failures++; $display("FAIL reset_flags: hold=%b ready=%b ovf=%b expected 0 0 0", cpu_hold, ld_ready, ld_overflow); end
    checks++; if (cpu_gnt !== 1'b0 || mem_en !== 1'b0) begin
      failures++; $display("FAIL reset_port: gnt=%b mem_en=%b expected 0 0", cpu_gnt, mem_en); end
    @(negedge clk); reset = 1'b0; cpu_req = 1'b0; #1;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL reset_release: rvalid=%b hold=%b expected 0 0", cpu_rvalid, cpu_hold); end
  endtask

  task automatic test_cpu_read();
    bd_write(12'h050, 8'hF0);
    @(negedge clk); cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'h050; #1;
    checks++; if (cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 12'h050) begin
      failures++; $display("FAIL cpu_read_issue: gnt=%b en=%b wr=%b addr=%h expected 1 1 0 050", cpu_gnt, mem_en, mem_write, mem_addr); end
    @(negedge clk); cpu_req = 1'b0; #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'hF0) begin
      failures++; $display("FAIL cpu_read_data: rvalid=%b rdata=%h expected 1 F0", cpu_rvalid, cpu_rdata); end
    @(negedge clk); cpu_req = 1'b1; cpu_write = 1'b1; cpu_addr = 12'h010; cpu_wdata = 8'h55; #1;
    checks++; if (cpu_rvalid !== 1'b0 || cpu_gnt !== 1'b1 || mem_en !== 1'b1 || mem_write !== 1'b1 ||
                  mem_addr !== 12'h010 || mem_wdata !== 8'h55) begin
      failures++; $display("FAIL cpu_low_write: rvalid=%b gnt=%b en=%b wr=%b addr=%h data=%h expected 0 1 1 1 010 55",
                           cpu_rvalid, cpu_gnt, mem_en, mem_write, mem_addr, mem_wdata); end
    @(negedge clk); cpu_req = 1'b0; cpu_write = 1'b0; #1;
    checks++; if (cpu_rvalid !== 1'b0) begin
      failures++; $display("FAIL cpu_write_no_rvalid: rvalid=%b expected 0", cpu_rvalid); end
  endtask

  task automatic test_cpu_random();
    bit          prev_rd;
    bit          rd;
    logic [11:0] a;
    logic [7:0]  d, e;
    prev_rd = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      rd = ($urandom_range(0, 1) == 1);
      a  = 12'($urandom_range(0, 4095));
      d  = 8'($urandom_range(0, 255));
      @(negedge clk); cpu_req = 1'b1; cpu_write = ~rd; cpu_addr = a; cpu_wdata = d; #1;
      checks++; if (cpu_gnt !== 1'b1 || mem_addr !== a) begin
        failures++; $display("FAIL rand_gnt[%0d]: gnt=%b addr=%h expected 1 %h", i, cpu_gnt, mem_addr, a); end
      checks++; if (cpu_rvalid !== prev_rd) begin
        failures++; $display("FAIL rand_rvalid[%0d]: got %b expected %b", i, cpu_rvalid, prev_rd); end
      if (prev_rd && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++; if (cpu_rdata !== e) begin
          failures++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, cpu_rdata, e); end
      end
      if (rd) exp_q.push_back(exp_mem[a]);
      else if (a >= PROG_BASE) exp_mem[a] = d;
      prev_rd = rd;
    end
    @(negedge clk); cpu_req = 1'b0; cpu_write = 1'b0; #1;
    checks++; if (cpu_rvalid !== prev_rd) begin
      failures++; $display("FAIL rand_rvalid_last: got %b expected %b", cpu_rvalid, prev_rd); end
    if (prev_rd && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++; if (cpu_rdata !== e) begin
        failures++; $display("FAIL rand_rdata_last: got %h expected %h", cpu_rdata, e); end
    end
    checks++; if (exp_q.size() != 0 || ram_diffs() != 0) begin
      failures++; $display("FAIL rand_final: pending=%0d ram_diffs=%0d expected 0 0", exp_q.size(), ram_diffs()); end
  endtask

  task automatic test_download();
    int errs;
    bd_write(12'h300, 8'hAA);
    bd_write(12'h100, 8'h5A);
    @(negedge clk); dl_active = 1'b1; #1;
    checks++; if (cpu_hold !== 1'b0 || mem_en !== 1'b0) begin
      failures++; $display("FAIL dl_rise_cycle: hold=%b en=%b expected 0 0", cpu_hold, mem_en); end
    run_clear(PROG_BASE, CLR_LEN, errs);
    model_zero(int'(PROG_BASE), 4095);
    checks++; if (errs != 0) begin
      failures++; $display("FAIL clear_sequence: bad_cycles=%0d expected 0", errs); end
    @(negedge clk); #1;
    checks++; if (ld_ready !== 1'b1 || cpu_hold !== 1'b1 || mem_en !== 1'b0) begin
      failures++; $display("FAIL clear_to_load: ready=%b hold=%b en=%b expected 1 1 0", ld_ready, cpu_hold, mem_en); end
    checks++; if (ram[12'h300] !== 8'h00 || ram[12'h100] !== 8'h5A) begin
      failures++; $display("FAIL clear_ram: ram300=%h ram100=%h expected 00 5A", ram[12'h300], ram[12'h100]); end
    checks++; if (ram_diffs() != 0) begin
      failures++; $display("FAIL clear_image: diffs=%0d expected 0", ram_diffs()); end
  endtask

  task automatic test_load();
    logic [11:0] la [$];
    logic [7:0]  ldv [$];
    logic [11:0] a;
    logic [7:0]  d;
    int          sum;
    exp_ovf = 1'b0;
    la.push_back(12'h000); ldv.push_back(8'h12);
    la.push_back(12'h001); ldv.push_back(8'h34);
    la.push_back(12'hE00); ldv.push_back(8'h99);
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) la.push_back(12'($urandom_range(12'hE00, 12'hFFF)));
      else la.push_back(12'($urandom_range(2, 12'hDFF)));
      ldv.push_back(8'($urandom_range(0, 255)));
    end
    foreach (la[i]) begin
      @(negedge clk); ld_valid = 1'b1; ld_addr = la[i]; ld_data = ldv[i]; #1;
      checks++; if (ld_ready !== 1'b1 || ld_overflow !== exp_ovf) begin
        failures++; $display("FAIL load_state[%0d]: ready=%b ovf=%b expected 1 %b", i, ld_ready, ld_overflow, exp_ovf); end
      sum = int'(PROG_BASE) + int'(la[i]);
      if (sum < 4096) begin
        checks++; if (mem_en !== 1'b1 || mem_write !== 1'b1 || mem_addr !== 12'(sum) || mem_wdata !== ldv[i]) begin
          failures++; $display("FAIL load_write[%0d]: en=%b wr=%b addr=%h data=%h expected 1 1 %h %h",
                               i, mem_en, mem_write, mem_addr, mem_wdata, 12'(sum), ldv[i]); end
      end else begin
        checks++; if (mem_en !== 1'b0) begin
          failures++; $display("FAIL load_overflow_nowrite[%0d]: en=%b expected 0", i, mem_en); end
      end
      model_load(la[i], ldv[i]);
    end
    @(negedge clk); ld_valid = 1'b0; #1;
    checks++; if (ld_overflow !== 1'b1) begin
      failures++; $display("FAIL load_overflow_flag: got %b expected 1", ld_overflow); end
    a = 12'($urandom_range(2, 12'hDFF));
    d = 8'($urandom_range(0, 255));
    @(negedge clk); dl_active = 1'b0; ld_valid = 1'b1; ld_addr = a; ld_data = d; #1;
    checks++; if (ld_ready !== 1'b1 || mem_en !== 1'b1 || mem_addr !== PROG_BASE + a || mem_wdata !== d) begin
      failures++; $display("FAIL load_last_byte: ready=%b en=%b addr=%h data=%h expected 1 1 %h %h",
                           ld_ready, mem_en, mem_addr, mem_wdata, PROG_BASE + a, d); end
    model_load(a, d);
    @(negedge clk); ld_valid = 1'b0; #1;
    checks++; if (cpu_hold !== 1'b0 || ld_ready !== 1'b0 || ld_overflow !== 1'b1) begin
      failures++; $display("FAIL load_exit: hold=%b ready=%b ovf=%b expected 0 0 1", cpu_hold, ld_ready, ld_overflow); end
    checks++; if (ram[12'h200] !== 8'h12 || ram[12'h201] !== 8'h34 || ram_diffs() != 0) begin
      failures++; $display("FAIL load_image: ram200=%h ram201=%h diffs=%0d expected 12 34 0",
                           ram[12'h200], ram[12'h201], ram_diffs()); end
  endtask

  task automatic test_contention();
    int errs;
    @(negedge clk); cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 12'h300; dl_active = 1'b1; #1;
    checks++; if (cpu_gnt !== 1'b0 || mem_en !== 1'b0 || cpu_hold !== 1'b0) begin
      failures++; $display("FAIL contend_rise: gnt=%b en=%b hold=%b expected 0 0 0", cpu_gnt, mem_en, cpu_hold); end
    run_clear(PROG_BASE, CLR_LEN, errs);
    model_zero(int'(PROG_BASE), 4095);
    checks++; if (errs != 0) begin
      failures++; $display("FAIL contend_clear: bad_cycles=%0d expected 0", errs); end
    @(negedge clk); ld_valid = 1'b1; ld_addr = 12'h100; ld_data = 8'h77; #1;
    checks++; if (ld_overflow !== 1'b0 || cpu_gnt !== 1'b0 || cpu_hold !== 1'b1 || mem_addr !== 12'h300) begin
      failures++; $display("FAIL contend_load: ovf=%b gnt=%b hold=%b addr=%h expected 0 0 1 300",
                           ld_overflow, cpu_gnt, cpu_hold, mem_addr); end
    model_load(12'h100, 8'h77);
    @(negedge clk); ld_valid = 1'b0; dl_active = 1'b0; #1;
    checks++; if (cpu_gnt !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++; $display("FAIL contend_dl_fall: gnt=%b hold=%b expected 0 1", cpu_gnt, cpu_hold); end
    @(negedge clk); #1;
    checks++; if (cpu_gnt !== 1'b1 || cpu_hold !== 1'b0 || mem_addr !== 12'h300) begin
      failures++; $display("FAIL contend_grant: gnt=%b hold=%b addr=%h expected 1 0 300", cpu_gnt, cpu_hold, mem_addr); end
    @(negedge clk); cpu_req = 1'b0; #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_mem[12'h300]) begin
      failures++; $display("FAIL contend_rdata: rvalid=%b rdata=%h expected 1 %h", cpu_rvalid, cpu_rdata, exp_mem[12'h300]); end
  endtask

  task automatic test_read_in_flight();
    logic [11:0] a;
    bd_fill_from(PROG_BASE, int'($urandom_range(0, 1000)));
    a = 12'($urandom_range(12'h200, 12'hFFF));
    @(negedge clk); cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = a; #1;
    checks++; if (cpu_gnt !== 1'b1) begin
      failures++; $display("FAIL inflight_gnt: got %b expected 1", cpu_gnt); end
    @(negedge clk); cpu_req = 1'b0; dl_active = 1'b1; #1;
    checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp_mem[a] || cpu_gnt !== 1'b0) begin
      failures++; $display("FAIL inflight_rdata: rvalid=%b rdata=%h gnt=%b expected 1 %h 0", cpu_rvalid, cpu_rdata, cpu_gnt, exp_mem[a]); end
  endtask

  task automatic test_reset_mid_clear();
    int errs;
    run_clear(PROG_BASE, 12'h400 - PROG_BASE, errs);
    model_zero(int'(PROG_BASE), 12'h3FF);
    checks++; if (errs != 0) begin
      failures++; $display("FAIL midclear_sequence: bad_cycles=%0d expected 0", errs); end
    @(negedge clk); reset = 1'b1; dl_active = 1'b0; #1;
    checks++; if (mem_en !== 1'b0) begin
      failures++; $display("FAIL midclear_reset_port: en=%b expected 0", mem_en); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (cpu_hold !== 1'b0 || ld_ready !== 1'b0 || mem_en !== 1'b0) begin
      failures++; $display("FAIL midclear_after_reset: hold=%b ready=%b en=%b expected 0 0 0", cpu_hold, ld_ready, mem_en); end
    checks++; if (ram_diffs() != 0 || ram[12'h400] === 8'h00) begin
      failures++; $display("FAIL midclear_image: diffs=%0d ram400=%h expected 0 nonzero", ram_diffs(), ram[12'h400]); end
  endtask

  task automatic test_back_to_back();
    int errs;
    @(negedge clk); dl_active = 1'b1; #1;
    checks++; if (cpu_hold !== 1'b0) begin
      failures++; $display("FAIL restart_rise: hold=%b expected 0", cpu_hold); end
    run_clear(PROG_BASE, CLR_LEN, errs);
    model_zero(int'(PROG_BASE), 4095);
    checks++; if (errs != 0) begin
      failures++; $display("FAIL restart_clear: bad_cycles=%0d expected 0", errs); end
    @(negedge clk); dl_active = 1'b0; #1;
    checks++; if (ld_ready !== 1'b1) begin
      failures++; $display("FAIL restart_load: ready=%b expected 1", ld_ready); end
    @(negedge clk); #1;
    checks++; if (cpu_hold !== 1'b0 || ram_diffs() != 0) begin
      failures++; $display("FAIL restart_done: hold=%b diffs=%0d expected 0 0", cpu_hold, ram_diffs()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dl_active = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; exp_ovf = 1'b0;
    bd_fill_from(12'h000, 17);
    test_reset();
    test_cpu_read();
    test_cpu_random();
    test_download();
    test_load();
    test_contention();
    test_read_in_flight();
    test_reset_mid_clear();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
